// File: rtl/md5_crack_controller.sv
// md5_crack_controller: sequencer for one brute-force MD5 lane.
// Holds the 128-bit target digest, starts and stops the guess generator,
// tracks in-flight guesses through the fixed-latency MD5 pipeline and
// latches the first matching guess index.
// Optional build macro: CRACK_GUESS_CAPTURE_EN enables a guess delay line
// so the matching guess itself is reported on hit_guess.
//
// Handshakes: there is no valid/ready flow control. start and abort are
// single-cycle requests sampled on the clock edge, and abort wins over start.
// cfg_we is sampled on the edge and is ignored while busy. gen_done qualifies
// the guess that is on `guess` in the same cycle. A digest on hash_a..d is
// valid only when the internal valid pipe output is set.
// The FSM state is available as the signal `state` for checkers.
module md5_crack_controller #(
  parameter int PIPE_LATENCY = 64,
  parameter int IDX_W        = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_addr,
  input  logic [31:0]      cfg_data,
  input  logic             start,
  input  logic             abort,
  output logic             gen_reset,
  input  logic             gen_done,
  input  logic [127:0]     guess,
  input  logic [31:0]      hash_a,
  input  logic [31:0]      hash_b,
  input  logic [31:0]      hash_c,
  input  logic [31:0]      hash_d,
  output logic             busy,
  output logic             found,
  output logic             exhausted,
  output logic [IDX_W-1:0] hit_index,
  output logic [127:0]     hit_guess
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RUN       = 3'd1,
    S_DRAIN     = 3'd2,
    S_FOUND     = 3'd3,
    S_EXHAUSTED = 3'd4
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [31:0]             tgt [4];
  logic [PIPE_LATENCY-1:0] vpipe;
  logic [PIPE_LATENCY-1:0] vpipe_nxt;
  logic [IDX_W-1:0]        out_cnt;
  logic                    out_valid;
  logic                    match;
  logic                    run_entry;

  assign busy      = (state == S_RUN) || (state == S_DRAIN);
  assign found     = (state == S_FOUND);
  assign exhausted = (state == S_EXHAUSTED);
  assign gen_reset = (state != S_RUN);

  // The oldest valid-pipe bit lines up with the digest now on hash_a..d.
  assign out_valid = vpipe[PIPE_LATENCY-1];
  assign match     = busy && out_valid &&
                     ({hash_a, hash_b, hash_c, hash_d} == {tgt[0], tgt[1], tgt[2], tgt[3]});
  assign run_entry = (state_nxt == S_RUN) && (state != S_RUN);

  // Next-state and valid-pipe update; a match wins over gen_done and over drain-empty.
  always_comb begin
    state_nxt = state;
    vpipe_nxt = vpipe;
    if (abort) begin
      state_nxt = S_IDLE;
      vpipe_nxt = '0;
    end else begin
      case (state)
        S_IDLE, S_FOUND, S_EXHAUSTED: begin
          if (start) begin
            state_nxt = S_RUN;
            vpipe_nxt = '0;
          end
        end
        S_RUN: begin
          vpipe_nxt = (vpipe << 1) | PIPE_LATENCY'(1);
          if (match) begin
            state_nxt = S_FOUND;
          end else if (gen_done) begin
            state_nxt = S_DRAIN;
          end
        end
        S_DRAIN: begin
          vpipe_nxt = vpipe << 1;
          if (match) begin
            state_nxt = S_FOUND;
          end else if (vpipe_nxt == '0) begin
            state_nxt = S_EXHAUSTED;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          vpipe_nxt = '0;
        end
      endcase
    end
  end

  // State register and valid pipe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      vpipe <= '0;
    end else begin
      state <= state_nxt;
      vpipe <= vpipe_nxt;
    end
  end

  // Target digest words; frozen while a search is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        tgt[i] <= '0;
      end
    end else if (cfg_we && !busy) begin
      tgt[cfg_addr] <= cfg_data;
    end
  end

  // Output-side guess index and first-match index capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_cnt   <= '0;
      hit_index <= '0;
    end else if (run_entry) begin
      out_cnt <= '0;
    end else if (match && !abort) begin
      hit_index <= out_cnt;
    end else if (busy && out_valid && !abort) begin
      out_cnt <= out_cnt + IDX_W'(1);
    end
  end

`ifdef CRACK_GUESS_CAPTURE_EN
  logic [127:0] gpipe [PIPE_LATENCY];
  logic [127:0] hit_guess_q;

  // Guess delay line aligned with the valid pipe; captures the guess on a match.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < PIPE_LATENCY; i++) begin
        gpipe[i] <= '0;
      end
      hit_guess_q <= '0;
    end else begin
      gpipe[0] <= guess;
      for (int i = 1; i < PIPE_LATENCY; i++) begin
        gpipe[i] <= gpipe[i-1];
      end
      if (match && !abort) begin
        hit_guess_q <= gpipe[PIPE_LATENCY-1];
      end
    end
  end

  assign hit_guess = hit_guess_q;
`else
  logic unused_guess;

  assign unused_guess = ^guess;
  assign hit_guess    = '0;
`endif

endmodule
